mux_2to1: RTL and testbench

//   Registered 2-to-1 data selector for WIDTH-bit operands.
//   - sel_i = 0 selects x1_i; sel_i = 1 selects x2_i.
//   - Result is captured on the clock and driven on y_o.
//   - Generic datapath steering element, used wherever one of two byte-wide
//     (default) sources feeds a downstream register stage.

---
 rtl/mux_2to1.sv | 33 +++
 tb/tb_mux_2to1.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// Registered 2-to-1 selector: y_o takes x2_i when sel_i is high, else x1_i,
// one clock after the inputs are sampled. Asynchronous active-low reset.
module mux_2to1 #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] x1_i,
  input  logic [WIDTH-1:0] x2_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  always_comb begin
    y_d = sel_i ? x2_i : x1_i;
  end

  // Output register: the only state; y_o is driven straight from the flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q <= RESET_VAL;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed and random checks of the registered 2-to-1 selector, including
// asynchronous reset assertion between clock edges.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] x1;
  logic [7:0] x2;
  logic       sel;
  logic [7:0] y;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mux_2to1 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .x1_i   (x1),
    .x2_i   (x2),
    .sel_i  (sel),
    .y_o    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x1    = 8'hA5;
    x2    = 8'h00;
    sel   = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (y !== 8'h00) $display("FAIL reset_hold cycle %0d: got %h expected %h", i, y, 8'h00);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (y !== 8'h00) $display("FAIL reset_release_before_edge: got %h expected %h", y, 8'h00);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y !== 8'hA5) $display("FAIL reset_first_capture: got %h expected %h", y, 8'hA5);
    else pass_cnt++;
  endtask

  task automatic test_select();
    x1  = 8'h3C;
    x2  = 8'hC3;
    sel = 1'b0;
    tick();
    total_cnt++;
    if (y !== 8'h3C) $display("FAIL select_x1: got %h expected %h", y, 8'h3C);
    else pass_cnt++;
    sel = 1'b1;
    #2;
    total_cnt++;
    if (y !== 8'h3C) $display("FAIL select_hold_between_edges: got %h expected %h", y, 8'h3C);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y !== 8'hC3) $display("FAIL select_x2: got %h expected %h", y, 8'hC3);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic [7:0] exp_v [3];
    logic       sel_v [3];
    exp_v[0] = 8'h00; exp_v[1] = 8'hFF; exp_v[2] = 8'h00;
    sel_v[0] = 1'b0;  sel_v[1] = 1'b1;  sel_v[2] = 1'b0;
    x1 = 8'h00;
    x2 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      sel = sel_v[i];
      tick();
      total_cnt++;
      if (y !== exp_v[i]) $display("FAIL boundary step %0d: got %h expected %h", i, y, exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    x1  = 8'h11;
    x2  = 8'h5A;
    sel = 1'b1;
    tick();
    total_cnt++;
    if (y !== 8'h5A) $display("FAIL async_pre: got %h expected %h", y, 8'h5A);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (y !== 8'h00) $display("FAIL async_assert: got %h expected %h", y, 8'h00);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (y !== 8'h00) $display("FAIL async_release_before_edge: got %h expected %h", y, 8'h00);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y !== 8'h5A) $display("FAIL async_recover: got %h expected %h", y, 8'h5A);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] exp_y;
    for (int i = 0; i < 16; i++) begin
      x1    = 8'($urandom_range(0, 255));
      x2    = 8'($urandom_range(0, 255));
      sel   = 1'($urandom_range(0, 1));
      exp_y = sel ? x2 : x1;
      tick();
      total_cnt++;
      if (y !== exp_y) $display("FAIL random cycle %0d: got %h expected %h", i, y, exp_y);
      else pass_cnt++;
    end
  endtask

  task automatic test_equal();
    x1 = 8'h77;
    x2 = 8'h77;
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      tick();
      total_cnt++;
      if (y !== 8'h77) $display("FAIL equal_inputs cycle %0d: got %h expected %h", i, y, 8'h77);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_boundary();
    test_async_reset();
    test_random();
    test_equal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
